imem_fetch_responder: RTL and testbench

- Instruction-memory responder that serves the fetch stage's PC requests and returns the 32-bit instruction word.
- Sits between the fetch stage and the decode stage.
- Single outstanding request, programmable wait states, response backpressure (decode stall) and flush on branch redirect.
- Includes a word-wide loader write port for test/boot image loading.

---
 rtl/imem_fetch_responder.sv | 200 ++++++++++++++++++++
 tb/tb_imem_fetch_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: serves one fetch PC request at a time and returns the 32-bit word.
// Latency: WAIT_STATES+1 cycles, counting the accept cycle; WAIT_STATES=0 gives one instruction per cycle.
// Backpressure: the response is held stable while rsp_ready_i is low; no new request is accepted meanwhile.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), synchronous active-low reset
//   req_valid_i/req_pc_i/req_ready_o    fetch request handshake (byte PC)
//   flush_i             drops any outstanding request or response (highest priority)
//   rsp_valid_o/rsp_ready_i, rsp_pc_o, rsp_instr_o, rsp_err_o   response to decode
//   wr_en_i/wr_addr_i/wr_data_i         word-wide loader port, active in every state and in reset
// Optional build macro IMEM_PERF_CNT_EN adds saturating counters:
//   perf_req_cnt_o (accepts), perf_stall_cnt_o (stalled response cycles),
//   perf_flush_cnt_o (flushes that threw away a WAIT or RESP entry).
module imem_fetch_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   input  logic [31:0] req_pc_i,
   output logic        req_ready_o,
   input  logic        flush_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_pc_o,
   output logic [31:0] rsp_instr_o,
   output logic        rsp_err_o,
   input  logic        wr_en_i,
   input  logic [31:0] wr_addr_i,
   input  logic [31:0] wr_data_i
`ifdef IMEM_PERF_CNT_EN
   ,
   output logic [31:0] perf_req_cnt_o,
   output logic [31:0] perf_stall_cnt_o,
   output logic [31:0] perf_flush_cnt_o
`endif
);

   localparam int unsigned AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_pc;
   logic        r_err;
   logic [31:0] r_rsp_pc;
   logic [31:0] r_rsp_instr;
   logic        r_rsp_err;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic        w_req_fire;
   logic        w_req_err;
   logic        w_load_rsp;
   logic [31:0] w_src_pc;
   logic        w_src_err;
   logic        w_wr_ok;
   logic        w_unused;

   // Range is checked on the full 30-bit word index so large PCs never alias into the array.
   assign w_req_err = (req_pc_i[1:0] != 2'b00) || ({2'b00, req_pc_i[31:2]} >= DEPTH_WORDS);
   assign w_wr_ok   = wr_en_i && ({2'b00, wr_addr_i[31:2]} < DEPTH_WORDS);
   assign w_unused  = ^wr_addr_i[1:0];

   assign req_ready_o = !flush_i && ((r_state == IDLE) || ((r_state == RESP) && rsp_ready_i));
   assign w_req_fire  = req_valid_i && req_ready_o;

   // Entering RESP from WAIT uses the latched request; from IDLE/RESP it is the request accepted now.
   assign w_src_pc  = (r_state == WAIT) ? r_pc  : req_pc_i;
   assign w_src_err = (r_state == WAIT) ? r_err : w_req_err;

   assign rsp_valid_o = (r_state == RESP);
   assign rsp_pc_o    = r_rsp_pc;
   assign rsp_instr_o = r_rsp_instr;
   assign rsp_err_o   = r_rsp_err;

   always_comb begin
      w_next_state = r_state;
      w_load_rsp   = 1'b0;
      if (flush_i) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req_fire) begin
                  w_next_state = (WAIT_STATES == 0) ? RESP : WAIT;
                  w_load_rsp   = (WAIT_STATES == 0);
               end
            end
            WAIT: begin
               if (r_cnt == 4'd0) begin
                  w_next_state = RESP;
                  w_load_rsp   = 1'b1;
               end
            end
            RESP: begin
               if (w_req_fire) begin
                  w_next_state = (WAIT_STATES == 0) ? RESP : WAIT;
                  w_load_rsp   = (WAIT_STATES == 0);
               end else if (rsp_ready_i) begin
                  w_next_state = IDLE;
               end
            end
            default: w_next_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_cnt <= 4'd0;
         r_pc  <= 32'd0;
         r_err <= 1'b0;
      end else begin
         if (w_req_fire) begin
            r_pc  <= req_pc_i;
            r_err <= w_req_err;
         end
         if (w_req_fire && (WAIT_STATES != 0)) begin
            r_cnt <= WS_LOAD;
         end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   // Response registers only change on entry to RESP, which keeps them stable under a decode stall.
   // The array read here sees the pre-edge contents, so a same-edge loader write returns old data.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_rsp_pc    <= 32'd0;
         r_rsp_instr <= 32'd0;
         r_rsp_err   <= 1'b0;
      end else if (w_load_rsp) begin
         r_rsp_pc  <= w_src_pc;
         r_rsp_err <= w_src_err;
         if (w_src_err) begin
            r_rsp_instr <= NOP_INSTR;
         end else begin
            r_rsp_instr <= r_mem[w_src_pc[AW+1:2]];
         end
      end
   end

   // Loader port is independent of reset so a boot image can be written while the core is held.
   always_ff @(posedge clk_i) begin
      if (w_wr_ok) begin
         r_mem[wr_addr_i[AW+1:2]] <= wr_data_i;
      end
   end

`ifdef IMEM_PERF_CNT_EN
   logic [31:0] r_perf_req;
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_flush;
   logic        w_flush_drop;

   // A response that handshakes in the flush cycle is consumed, not discarded.
   assign w_flush_drop = flush_i && ((r_state == WAIT) || ((r_state == RESP) && !rsp_ready_i));

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_perf_req   <= 32'd0;
         r_perf_stall <= 32'd0;
         r_perf_flush <= 32'd0;
      end else begin
         if (w_req_fire && (r_perf_req != 32'hFFFF_FFFF)) begin
            r_perf_req <= r_perf_req + 32'd1;
         end
         if (rsp_valid_o && !rsp_ready_i && (r_perf_stall != 32'hFFFF_FFFF)) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
         if (w_flush_drop && (r_perf_flush != 32'hFFFF_FFFF)) begin
            r_perf_flush <= r_perf_flush + 32'd1;
         end
      end
   end

   assign perf_req_cnt_o   = r_perf_req;
   assign perf_stall_cnt_o = r_perf_stall;
   assign perf_flush_cnt_o = r_perf_flush;
`endif

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: three instances (WAIT_STATES 0, 3, 2) share the loader port.
// Expected responses are queued when requests are issued; a monitor process pops on every handshake.
// Directed checks cover reset state, wait-state latency, stall stability, errors, flush and reset.
module tb_imem_fetch_responder;

   localparam int          DEPTH = 64;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   typedef struct {
      int          k;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req_valid, req_ready, flush, rsp_valid, rsp_ready, rsp_err;
   logic [31:0] req_pc [3];
   logic [31:0] rsp_pc [3];
   logic [31:0] rsp_instr [3];
   logic        wr_en;
   logic [31:0] wr_addr, wr_data;
`ifdef IMEM_PERF_CNT_EN
   logic [31:0] perf_req [3];
   logic [31:0] perf_stall [3];
   logic [31:0] perf_flush [3];
`endif

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned WS = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
      imem_fetch_responder #(
         .DEPTH_WORDS(DEPTH),
         .WAIT_STATES(WS),
         .NOP_INSTR  (NOP)
      ) u_dut (
         .clk_i      (clk),
         .rst_i      (rst_n),
         .req_valid_i(req_valid[g]),
         .req_pc_i   (req_pc[g]),
         .req_ready_o(req_ready[g]),
         .flush_i    (flush[g]),
         .rsp_valid_o(rsp_valid[g]),
         .rsp_ready_i(rsp_ready[g]),
         .rsp_pc_o   (rsp_pc[g]),
         .rsp_instr_o(rsp_instr[g]),
         .rsp_err_o  (rsp_err[g]),
         .wr_en_i    (wr_en),
         .wr_addr_i  (wr_addr),
         .wr_data_i  (wr_data)
`ifdef IMEM_PERF_CNT_EN
         ,
         .perf_req_cnt_o  (perf_req[g]),
         .perf_stall_cnt_o(perf_stall[g]),
         .perf_flush_cnt_o(perf_flush[g])
`endif
      );
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int k, input logic [31:0] pc, input logic [31:0] instr, input logic err);
      exp_t e;
      e.k = k; e.pc = pc; e.instr = instr; e.err = err;
      exp_q.push_back(e);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic monitor_edge();
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         if (rsp_valid[k] && rsp_ready[k]) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_rsp dut%0d: got pc %h, required no response", k, rsp_pc[k]);
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("rsp_dut%0d", k), 32'(k), 32'(e.k));
               chk($sformatf("rsp_pc_dut%0d", k), rsp_pc[k], e.pc);
               chk($sformatf("rsp_instr_dut%0d", k), rsp_instr[k], e.instr);
               chk($sformatf("rsp_err_dut%0d", k), 32'(rsp_err[k]), 32'(e.err));
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; flush = '0; rsp_ready = '1;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      for (int k = 0; k < 3; k++) req_pc[k] = '0;

      fork
         forever begin
            @(negedge clk);
            monitor_edge();
         end
      join_none

      // Reset, with a loader write while reset is held
      cyc();
      wr(32'h10, 32'hDEAD_BEEF);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("reset_valid", 32'(rsp_valid[k]), 32'd0);
         chk("reset_pc", rsp_pc[k], 32'd0);
         chk("reset_instr", rsp_instr[k], 32'd0);
         chk("reset_err", 32'(rsp_err[k]), 32'd0);
      end
      rst_n = 1'b1;
      cyc();
      wr(32'h0, 32'h0050_0093);
      wr(32'h4, 32'h00A0_0113);
      wr(32'hB, 32'h00F0_0193);   // low address bits ignored: lands on word 2
      wr(32'(4 * DEPTH), 32'h1234_5678);

      // Back-to-back fetches, WAIT_STATES=0
      req_valid[0] = 1'b1; req_pc[0] = 32'h0; push(0, 32'h0, 32'h0050_0093, 1'b0);
      cyc();
      req_pc[0] = 32'h4; push(0, 32'h4, 32'h00A0_0113, 1'b0);
      @(negedge clk);
      chk("b2b_req_ready", 32'(req_ready[0]), 32'd1);
      cyc();
      req_pc[0] = 32'h10; push(0, 32'h10, 32'hDEAD_BEEF, 1'b0);
      cyc();
      req_valid[0] = 1'b0;
      cyc();
      cyc();

      // Wait-state latency, WAIT_STATES=3
      req_valid[1] = 1'b1; req_pc[1] = 32'h4; push(1, 32'h4, 32'h00A0_0113, 1'b0);
      cyc();
      req_valid[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("wait_valid_low", 32'(rsp_valid[1]), 32'd0);
         chk("wait_req_ready", 32'(req_ready[1]), 32'd0);
         cyc();
      end
      @(negedge clk);
      chk("wait_valid_rise", 32'(rsp_valid[1]), 32'd1);
      cyc();
      cyc();

      // Backpressure: five stalled cycles, loader overwrites the word mid-stall
      rsp_ready[0] = 1'b0;
      req_valid[0] = 1'b1; req_pc[0] = 32'h8; push(0, 32'h8, 32'h00F0_0193, 1'b0);
      cyc();
      req_pc[0] = 32'h0;
      wr_en = 1'b1; wr_addr = 32'h8; wr_data = 32'h0BAD_F00D;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid", 32'(rsp_valid[0]), 32'd1);
         chk("stall_pc", rsp_pc[0], 32'h8);
         chk("stall_instr", rsp_instr[0], 32'h00F0_0193);
         chk("stall_req_ready", 32'(req_ready[0]), 32'd0);
         cyc();
         wr_en = 1'b0;
      end
      rsp_ready[0] = 1'b1; push(0, 32'h0, 32'h0050_0093, 1'b0);
      @(negedge clk);
      chk("release_req_ready", 32'(req_ready[0]), 32'd1);
      cyc();
      req_valid[0] = 1'b0;
      cyc();
      cyc();

      // Error responses: misaligned, first out-of-range word, very large PC
      req_valid[0] = 1'b1;
      req_pc[0] = 32'h2; push(0, 32'h2, NOP, 1'b1);
      cyc();
      req_pc[0] = 32'(4 * DEPTH); push(0, 32'(4 * DEPTH), NOP, 1'b1);
      cyc();
      req_pc[0] = 32'hFFFF_FFFC; push(0, 32'hFFFF_FFFC, NOP, 1'b1);
      cyc();
      req_valid[0] = 1'b0;
      cyc();
      cyc();

      // Flush in the first WAIT cycle, WAIT_STATES=2
      req_valid[2] = 1'b1; req_pc[2] = 32'h8;
      cyc();
      req_pc[2] = 32'h0; flush[2] = 1'b1;
      @(negedge clk);
      chk("flush_req_ready", 32'(req_ready[2]), 32'd0);
      cyc();
      flush[2] = 1'b0; push(2, 32'h0, 32'h0050_0093, 1'b0);
      @(negedge clk);
      chk("flush_valid_low", 32'(rsp_valid[2]), 32'd0);
      chk("post_flush_ready", 32'(req_ready[2]), 32'd1);
      cyc();
      req_valid[2] = 1'b0;
      repeat (4) cyc();

      // Flush of a stalled response
      rsp_ready[0] = 1'b0; req_valid[0] = 1'b1; req_pc[0] = 32'h4;
      cyc();
      req_valid[0] = 1'b0; flush[0] = 1'b1;
      @(negedge clk);
      chk("pre_flush_valid", 32'(rsp_valid[0]), 32'd1);
      cyc();
      flush[0] = 1'b0;
      @(negedge clk);
      chk("flush_resp_valid", 32'(rsp_valid[0]), 32'd0);
      rsp_ready[0] = 1'b1;
      cyc();

`ifdef IMEM_PERF_CNT_EN
      chk("perf_req0", perf_req[0], 32'd9);
      chk("perf_stall0", perf_stall[0], 32'd6);
      chk("perf_flush0", perf_flush[0], 32'd1);
      chk("perf_req2", perf_req[2], 32'd2);
      chk("perf_flush2", perf_flush[2], 32'd1);
`endif

      // Reset while a response is stalled
      rsp_ready[0] = 1'b0; req_valid[0] = 1'b1; req_pc[0] = 32'h4;
      cyc();
      req_valid[0] = 1'b0; rst_n = 1'b0;
      cyc();
      @(negedge clk);
      chk("rst_mid_valid", 32'(rsp_valid[0]), 32'd0);
      chk("rst_mid_pc", rsp_pc[0], 32'd0);
      chk("rst_mid_instr", rsp_instr[0], 32'd0);
`ifdef IMEM_PERF_CNT_EN
      for (int k = 0; k < 3; k++) begin
         chk("rst_perf_req", perf_req[k], 32'd0);
         chk("rst_perf_stall", perf_stall[k], 32'd0);
         chk("rst_perf_flush", perf_flush[k], 32'd0);
      end
`endif
      rst_n = 1'b1; rsp_ready[0] = 1'b1;
      req_valid[0] = 1'b1; req_pc[0] = 32'h0; push(0, 32'h0, 32'h0050_0093, 1'b0);
      cyc();
      req_pc[0] = 32'h8; push(0, 32'h8, 32'h0BAD_F00D, 1'b0);
      cyc();
      req_valid[0] = 1'b0;
      repeat (3) cyc();

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
